// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 640x480@60 parameters, derived totals and sync windows.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int unsigned H_DISPLAY_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_DISPLAY_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  function automatic int unsigned span(input int unsigned display, input int unsigned front,
                                       input int unsigned sync, input int unsigned back);
    return display + front + sync + back;
  endfunction

  localparam int unsigned H_TOTAL = span(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int unsigned V_TOTAL = span(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  // Sync windows are inclusive on both ends.
  localparam int unsigned H_SYNC_START = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int unsigned V_SYNC_START = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

endpackage

// File: rtl/vga_pixel_tick.sv
// Divide-by-2 pixel clock: toggles on every rising edge of the board clock.
module vga_pixel_tick (
  input  logic clk,
  input  logic reset,
  output logic vga_clock
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vga_clock <= 1'b0;
    else       vga_clock <= ~vga_clock;
  end

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel/line counters plus registered, zero-skew active-low sync pulses.
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic         clk,
  input  logic         reset,
  output logic         hsync,
  output logic         vsync,
  output logic         video_on,
  output logic         p_tick,
  output logic [9:0]   x,
  output logic [9:0]   y
);

  localparam cnt_t H_LAST = cnt_t'(span(H_DISPLAY, H_FRONT, H_SYNC, H_BACK) - 1);
  localparam cnt_t V_LAST = cnt_t'(span(V_DISPLAY, V_FRONT, V_SYNC, V_BACK) - 1);
  localparam cnt_t H_SS   = cnt_t'(H_DISPLAY + H_FRONT);
  localparam cnt_t H_SE   = cnt_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam cnt_t V_SS   = cnt_t'(V_DISPLAY + V_FRONT);
  localparam cnt_t V_SE   = cnt_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam cnt_t H_VIS  = cnt_t'(H_DISPLAY);
  localparam cnt_t V_VIS  = cnt_t'(V_DISPLAY);

  logic vga_clock;
  cnt_t x_next;
  cnt_t y_next;

  vga_pixel_tick u_pixel_tick (
    .clk       (clk),
    .reset     (reset),
    .vga_clock (vga_clock)
  );

  assign p_tick = vga_clock;

  always_comb begin
    x_next = x + 10'd1;
    y_next = y;
    if (x == H_LAST) begin
      x_next = '0;
      y_next = (y == V_LAST) ? '0 : y + 10'd1;
    end
  end

  // Syncs are decoded from the next counter values so they change on the same edge as x/y.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      x     <= '0;
      y     <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      x     <= x_next;
      y     <= y_next;
      hsync <= !((x_next >= H_SS) && (x_next <= H_SE));
      vsync <= !((y_next >= V_SS) && (y_next <= V_SE));
    end
  end

  assign video_on = (x < H_VIS) && (y < V_VIS);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default 640x480 instance and a shrunken-timing instance checked against a pixel model.
module tb_vga_sync;

  localparam int W = 24;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset_s = 1'b0;

  logic       hsync, vsync, video_on, p_tick;
  logic [9:0] x, y;
  logic       s_hsync, s_vsync, s_video_on, s_p_tick;
  logic [9:0] s_x, s_y;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_s_q[$];
  logic [W-1:0] obs;
  logic [W-1:0] e;

  // Model state per instance: 0 = default timing, 1 = shrunken timing.
  int   mx[2];
  int   my[2];
  logic ph[2];
  int   h_disp[2]  = '{640, 16};
  int   h_front[2] = '{16, 2};
  int   h_sync[2]  = '{96, 3};
  int   h_back[2]  = '{48, 2};
  int   v_disp[2]  = '{480, 12};
  int   v_front[2] = '{10, 2};
  int   v_sync[2]  = '{2, 2};
  int   v_back[2]  = '{33, 3};

  localparam logic [W-1:0] RESET_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};

  always #10 clk = ~clk;

  vga_sync dut (
    .clk      (clk),
    .reset    (reset),
    .hsync    (hsync),
    .vsync    (vsync),
    .video_on (video_on),
    .p_tick   (p_tick),
    .x        (x),
    .y        (y)
  );

  vga_sync #(
    .H_DISPLAY (16), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_DISPLAY (12), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
  ) dut_s (
    .clk      (clk),
    .reset    (reset_s),
    .hsync    (s_hsync),
    .vsync    (s_vsync),
    .video_on (s_video_on),
    .p_tick   (s_p_tick),
    .x        (s_x),
    .y        (s_y)
  );

  // ---------------- model / driver ----------------
  function automatic logic [W-1:0] exp_vec(input int i);
    int   hss, vss;
    logic hs, vs, von;
    hss = h_disp[i] + h_front[i];
    vss = v_disp[i] + v_front[i];
    hs  = !(mx[i] >= hss && mx[i] < hss + h_sync[i]);
    vs  = !(my[i] >= vss && my[i] < vss + v_sync[i]);
    von = (mx[i] < h_disp[i]) && (my[i] < v_disp[i]);
    return {10'(mx[i]), 10'(my[i]), hs, vs, von, ph[i]};
  endfunction

  task automatic model_step(input int i, input logic r);
    int ht, vt;
    ht = h_disp[i] + h_front[i] + h_sync[i] + h_back[i];
    vt = v_disp[i] + v_front[i] + v_sync[i] + v_back[i];
    if (r) begin
      ph[i] = 1'b0;
      mx[i] = 0;
      my[i] = 0;
    end else begin
      ph[i] = ~ph[i];
      if (ph[i]) begin
        if (mx[i] == ht - 1) begin
          mx[i] = 0;
          my[i] = (my[i] == vt - 1) ? 0 : my[i] + 1;
        end else begin
          mx[i] = mx[i] + 1;
        end
      end
    end
  endtask

  // One board-clock cycle: sample point is the falling edge, after the pixel edge settled.
  task automatic clk_cycle();
    @(negedge clk);
    model_step(0, reset);
    model_step(1, reset_s);
    exp_q.push_back(exp_vec(0));
    exp_s_q.push_back(exp_vec(1));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    reset = 1'b1;
    reset_s = 1'b1;
    #1;
    obs = {x, y, hsync, vsync, video_on, p_tick};
    checks++;
    if (obs !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_immediate got=%h exp=%h", obs, RESET_VEC);
    end
    repeat (3) begin
      clk_cycle();
      obs = {x, y, hsync, vsync, video_on, p_tick};
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_hold got=%h exp=%h", obs, e);
      end
      obs = {s_x, s_y, s_hsync, s_vsync, s_video_on, s_p_tick};
      e = exp_s_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_hold_small got=%h exp=%h", obs, e);
      end
    end
    reset = 1'b0;
    reset_s = 1'b0;
    clk_cycle();
    obs = {x, y, hsync, vsync, video_on, p_tick};
    e = exp_q.pop_front();
    void'(exp_s_q.pop_front());
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL first_pixel_vec got=%h exp=%h", obs, e);
    end
    checks++;
    if (x !== 10'd1) begin
      failures++;
      $display("FAIL first_pixel_x got=%0d exp=1", x);
    end
  endtask

  task automatic test_pixel_clock();
    logic p0, p1, p2;
    p0 = p_tick;
    clk_cycle();
    p1 = p_tick;
    obs = {x, y, hsync, vsync, video_on, p_tick};
    e = exp_q.pop_front();
    void'(exp_s_q.pop_front());
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL pclk_vec got=%h exp=%h", obs, e);
    end
    clk_cycle();
    p2 = p_tick;
    obs = {x, y, hsync, vsync, video_on, p_tick};
    e = exp_q.pop_front();
    void'(exp_s_q.pop_front());
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL pclk_vec got=%h exp=%h", obs, e);
    end
    checks++;
    if (p1 !== ~p0) begin
      failures++;
      $display("FAIL p_tick_half got=%b exp=%b", p1, ~p0);
    end
    checks++;
    if (p2 !== p0) begin
      failures++;
      $display("FAIL p_tick_period got=%b exp=%b", p2, p0);
    end
  endtask

  task automatic test_line();
    int         hs_low, hs_first;
    bit         wrap_seen;
    logic [9:0] px;
    hs_low = 0;
    hs_first = -1;
    wrap_seen = 0;
    px = x;
    for (int n = 0; n < 1700; n++) begin
      clk_cycle();
      obs = {x, y, hsync, vsync, video_on, p_tick};
      e = exp_q.pop_front();
      void'(exp_s_q.pop_front());
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL line_vec got=%h exp=%h", obs, e);
      end
      if (p_tick) begin
        if (y == 10'd0 && hsync == 1'b0) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(x);
        end
        if (px == 10'd799 && x == 10'd0 && y == 10'd1) wrap_seen = 1;
        px = x;
      end
    end
    checks++;
    if (hs_low != 96) begin
      failures++;
      $display("FAIL hsync_width got=%0d exp=96", hs_low);
    end
    checks++;
    if (hs_first != 656) begin
      failures++;
      $display("FAIL hsync_start got=%0d exp=656", hs_first);
    end
    checks++;
    if (!wrap_seen) begin
      failures++;
      $display("FAIL line_wrap got=0 exp=1");
    end
  endtask

  task automatic test_small_frame();
    int       ticks, frames, frame_len, vs_low, vs_min, vs_max;
    logic [3:0] seen;
    ticks = 0;
    frames = 0;
    frame_len = 0;
    vs_low = 0;
    vs_min = 1023;
    vs_max = -1;
    seen = '0;
    for (int n = 0; n < 2700; n++) begin
      clk_cycle();
      void'(exp_q.pop_front());
      obs = {s_x, s_y, s_hsync, s_vsync, s_video_on, s_p_tick};
      e = exp_s_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL frame_vec got=%h exp=%h", obs, e);
      end
      if (s_p_tick) begin
        ticks++;
        if (s_x == 10'd0 && s_y == 10'd0) begin
          if (frames == 1) frame_len = ticks;
          if (frames < 2) frames++;
          ticks = 0;
        end else if (frames == 1 && !s_vsync) begin
          vs_low++;
          if (int'(s_y) < vs_min) vs_min = int'(s_y);
          if (int'(s_y) > vs_max) vs_max = int'(s_y);
        end
        if (s_x == 10'd15 && s_y == 10'd11) begin
          seen[0] = 1'b1;
          checks++;
          if (s_video_on !== 1'b1) begin
            failures++;
            $display("FAIL video_on_last_visible got=%b exp=1", s_video_on);
          end
        end
        if ((s_x == 10'd16 && s_y == 10'd0) || (s_x == 10'd0 && s_y == 10'd12) ||
            (s_x == 10'd22 && s_y == 10'd18)) begin
          seen[(s_x == 10'd16) ? 1 : (s_y == 10'd12) ? 2 : 3] = 1'b1;
          checks++;
          if (s_video_on !== 1'b0) begin
            failures++;
            $display("FAIL video_on_blank x=%0d y=%0d got=%b exp=0", s_x, s_y, s_video_on);
          end
        end
      end
    end
    checks++;
    if (frames != 2 || frame_len != 23 * 19) begin
      failures++;
      $display("FAIL frame_length got=%0d exp=%0d", frame_len, 23 * 19);
    end
    checks++;
    if (vs_low != 2 * 23) begin
      failures++;
      $display("FAIL vsync_width got=%0d exp=%0d", vs_low, 2 * 23);
    end
    checks++;
    if (vs_min != 14 || vs_max != 15) begin
      failures++;
      $display("FAIL vsync_lines got=%0d..%0d exp=14..15", vs_min, vs_max);
    end
    checks++;
    if (seen !== 4'hf) begin
      failures++;
      $display("FAIL video_on_corners_seen got=%b exp=1111", seen);
    end
  endtask

  task automatic test_mid_reset();
    bit hit;
    hit = 0;
    for (int n = 0; n < 1700 && !hit; n++) begin
      clk_cycle();
      obs = {x, y, hsync, vsync, video_on, p_tick};
      e = exp_q.pop_front();
      void'(exp_s_q.pop_front());
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL pre_reset_vec got=%h exp=%h", obs, e);
      end
      if (p_tick && x == 10'd700) hit = 1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL mid_reset_timeout got=%0d exp=700", x);
    end
    // x=700 sits inside the hsync pulse, so the immediate check also proves the pulse is cut.
    reset = 1'b1;
    #1;
    obs = {x, y, hsync, vsync, video_on, p_tick};
    checks++;
    if (obs !== RESET_VEC) begin
      failures++;
      $display("FAIL mid_reset_immediate got=%h exp=%h", obs, RESET_VEC);
    end
    repeat (2) begin
      clk_cycle();
      obs = {x, y, hsync, vsync, video_on, p_tick};
      e = exp_q.pop_front();
      void'(exp_s_q.pop_front());
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mid_reset_hold got=%h exp=%h", obs, e);
      end
    end
    reset = 1'b0;
    repeat (6) begin
      clk_cycle();
      obs = {x, y, hsync, vsync, video_on, p_tick};
      e = exp_q.pop_front();
      void'(exp_s_q.pop_front());
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL post_reset_vec got=%h exp=%h", obs, e);
      end
    end
    checks++;
    if ({x, y} !== {10'd3, 10'd0}) begin
      failures++;
      $display("FAIL post_reset_xy got=%0d,%0d exp=3,0", x, y);
    end
  endtask

  initial begin
    mx = '{0, 0};
    my = '{0, 0};
    ph = '{1'b0, 1'b0};
    test_reset();
    test_pixel_clock();
    test_line();
    test_small_frame();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
